// File: rtl/enum_seq_pkg.sv
// Shared types for the enum sequence checker: observed symbol codes, checker FSM
// states and the successor function used by both design and integration code.
package enum_seq_pkg;

    typedef enum logic [1:0] {ts0, ts1, ts2, ts3} states_t;

    typedef enum logic [1:0] {HUNT, LOCKED, LOST} chk_state_t;

    // ts3 is only part of the cycle when the four-state wrap is selected.
    function automatic states_t next_state(states_t s, logic wrap4);
        case (s)
            ts0:     return ts1;
            ts1:     return ts2;
            ts2:     return wrap4 ? ts3 : ts0;
            default: return ts0;
        endcase
    endfunction

    function automatic logic is_legal(states_t s, logic wrap4);
        return wrap4 || (s != ts3);
    endfunction

endpackage

// File: rtl/enum_seq_satcnt.sv
// 8-bit saturating event counter; a clear in the same cycle as an increment
// leaves the count at one so a fresh error is never lost.
module enum_seq_satcnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'h00;
        end else if (clr) begin
            count <= inc ? 8'h01 : 8'h00;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'h01;
        end
    end

endmodule

// File: rtl/enum_seq_checker.sv
// Checks that a stream of state codes follows the ts0->ts1->ts2(->ts3) cycle,
// locking after LOCK_CNT correct successors. Define ENUM_SEQ_CNT_EN to build err_cnt.
module enum_seq_checker
    import enum_seq_pkg::*;
#(
    parameter int LOCK_CNT = 2,
    parameter bit WRAP4    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sym_valid,
    input  logic [1:0] sym,
    input  logic       err_clr,
    output logic       locked,
    output logic [1:0] exp_state,
    output logic       err_pulse,
    output logic       err_sticky,
    output logic [7:0] err_cnt
);

    // run counts the seed symbol plus each correct successor, so lock needs LOCK_CNT+1.
    localparam logic [4:0] LOCK_RUN = 5'(LOCK_CNT + 1);

    chk_state_t state;
    states_t    exp_q;
    logic [4:0] run;

    states_t    sym_s;
    states_t    sym_next;
    logic       sym_legal;
    logic       sym_match;
    logic [4:0] hunt_run;
    logic       error;

    assign sym_s     = states_t'(sym);
    assign sym_next  = next_state(sym_s, WRAP4);
    assign sym_legal = is_legal(sym_s, WRAP4);
    assign sym_match = (sym_s == exp_q);
    assign hunt_run  = (sym_match && (run != 5'd0)) ? run + 5'd1 : 5'd1;
    assign error     = sym_valid && (state == LOCKED) && !sym_match;
    assign exp_state = exp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            run        <= 5'd0;
            exp_q      <= ts0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            err_pulse <= error;
            if (error) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end

            if (sym_valid) begin
                case (state)
                    HUNT: begin
                        if (sym_legal) begin
                            exp_q <= sym_next;
                            if (hunt_run == LOCK_RUN) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                run    <= 5'd0;
                            end else begin
                                run <= hunt_run;
                            end
                        end else begin
                            run <= 5'd0;
                        end
                    end
                    LOCKED: begin
                        if (sym_match) begin
                            exp_q <= sym_next;
                        end else begin
                            state  <= LOST;
                            locked <= 1'b0;
                            exp_q  <= next_state(exp_q, WRAP4);
                        end
                    end
                    LOST: begin
                        // One slipped symbol is forgiven; a second miss drops back to hunting.
                        if (sym_match) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            exp_q  <= sym_next;
                        end else begin
                            state <= HUNT;
                            if (sym_legal) begin
                                run   <= 5'd1;
                                exp_q <= sym_next;
                            end else begin
                                run <= 5'd0;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        run    <= 5'd0;
                    end
                endcase
            end
        end
    end

`ifdef ENUM_SEQ_CNT_EN
    enum_seq_satcnt u_satcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (error),
        .clr   (err_clr),
        .count (err_cnt)
    );
`else
    assign err_cnt = 8'h00;
`endif

endmodule
